// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared defines for the divider: FSM states, handshake levels, bus widths.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int RegBusW       = 32;
  localparam int DoubleRegBusW = 64;

  typedef logic [RegBusW-1:0]       reg_bus_t;
  typedef logic [DoubleRegBusW-1:0] double_reg_bus_t;

  // Magnitude of an operand; only negative values in signed mode are flipped.
  function automatic reg_bus_t mag32(input reg_bus_t v, input logic is_signed);
    return (is_signed && v[RegBusW-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between EX and the divider.
interface div_unit_if;
  import div_unit_pkg::*;

  logic            signed_div_i;
  reg_bus_t        opdata1_i;
  reg_bus_t        opdata2_i;
  logic            start_i;
  logic            annul_i;
  double_reg_bus_t result_o;
  logic            ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step (
  input  logic [32:0] acc,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [33:0] diff;

  // The partial remainder is always below the divisor, so a non-borrowing result fits in 32 bits.
  assign diff     = {1'b0, acc} - {2'b00, divisor};
  assign q_bit    = ~diff[33];
  assign rem_next = q_bit ? diff[31:0] : acc[31:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-cycle restoring divider (DIV/DIVU), result as {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: divisor 0 short-circuits through DivByZero with a zero result.
module div_unit
  import div_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  div_state_e state_q, state_d;
  logic       ready_q, ready_d;
  logic [5:0] cnt_q;
  reg_bus_t   rem_q, dvd_q, dvs_q;
  logic       sign_a_q, sign_b_q, mode_q;

  reg_bus_t   step_rem;
  logic       step_q;
  reg_bus_t   q_final;
  logic       neg_q, neg_r;

  div_step u_step (
    .acc      ({rem_q, dvd_q[31]}),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // The dividend register doubles as the quotient shift register.
  assign q_final = {dvd_q[30:0], step_q};
  assign neg_q   = mode_q & (sign_a_q ^ sign_b_q);
  assign neg_r   = mode_q & sign_a_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DivFree;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_d = DivResultNotReady;
    case (state_q)
      DivFree: begin
        if (bus.start_i == DivStart && !bus.annul_i) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = (bus.opdata2_i == '0) ? DivByZero : DivOn;
`else
          state_d = DivOn;
`endif
        end
      end
      DivByZero: begin
        if (bus.annul_i || bus.start_i == DivStop) state_d = DivFree;
        else                                      state_d = DivEnd;
      end
      DivOn: begin
        if (bus.annul_i || bus.start_i == DivStop) state_d = DivFree;
        else if (cnt_q == 6'd31)                  state_d = DivEnd;
      end
      DivEnd: begin
        if (bus.start_i == DivStop) state_d = DivFree;
        else                        ready_d = DivResultReady;
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      case (state_q)
        DivFree: begin
          if (state_d == DivOn) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= mag32(bus.opdata1_i, bus.signed_div_i);
            dvs_q    <= mag32(bus.opdata2_i, bus.signed_div_i);
            sign_a_q <= bus.opdata1_i[31];
            sign_b_q <= bus.opdata2_i[31];
            mode_q   <= bus.signed_div_i;
          end else if (state_d == DivByZero) begin
            cnt_q <= '0;
            rem_q <= '0;
            dvd_q <= '0;
          end
        end
        DivOn: begin
          if (state_d == DivOn) begin
            cnt_q <= cnt_q + 6'd1;
            rem_q <= step_rem;
            dvd_q <= q_final;
          end else if (state_d == DivEnd) begin
            cnt_q <= cnt_q + 6'd1;
            rem_q <= neg_r ? (~step_rem + 32'd1) : step_rem;
            dvd_q <= neg_q ? (~q_final + 32'd1) : q_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = ready_q ? {rem_q, dvd_q} : '0;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vectors and corner sequences for div_unit.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // First edge is the start edge; returns edges after it until ready_o, or -1.
  task automatic measure(output int lat, output bit zero_ok);
    zero_ok = 1'b1;
    lat = -1;
    @(posedge clk); #1;
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~bus.signed_div_i;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) begin
        lat = i;
        break;
      end
      if (bus.result_o !== 64'd0) zero_ok = 1'b0;
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", 64'(bus.ready_o), 64'd0);
    check("drop_result", bus.result_o, 64'd0);
  endtask

  task automatic run_vec(input int idx);
    int lat;
    bit zok;
    bit st;
    @(negedge clk);
    bus.signed_div_i = vecs[idx].sgn;
    bus.opdata1_i    = vecs[idx].a;
    bus.opdata2_i    = vecs[idx].b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    measure(lat, zok);
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(vecs[idx].lat));
    check($sformatf("v%0d_result", idx), bus.result_o, vecs[idx].exp);
    check($sformatf("v%0d_zero_while_busy", idx), 64'(zok), 64'd1);
    st = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!bus.ready_o || bus.result_o !== vecs[idx].exp) st = 1'b0;
    end
    check($sformatf("v%0d_stable", idx), 64'(st), 64'd1);
    drop_start();
  endtask

  initial begin
    int lat;
    bit zok;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'h2, 32'hE},                 33};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0, 32'h8000_0000},        33};
`ifdef DIV_ZERO_FAST_EN
    vecs[3] = '{1'b0, 32'd7,          32'd0,        64'd0,                          2};
    vecs[4] = '{1'b1, 32'd7,          32'd0,        64'd0,                          2};
`else
    vecs[3] = '{1'b0, 32'd7,          32'd0,        {32'd7, 32'hFFFF_FFFF},         33};
    vecs[4] = '{1'b1, 32'd7,          32'd0,        {32'd7, 32'hFFFF_FFFF},         33};
`endif
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'h0, 32'hFFFF_FFFF},         33};
    vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD},        33};
    vecs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'h0},        33};
    vecs[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE},        33};
    vecs[9] = '{1'b0, 32'd9,          32'd3,        {32'h0, 32'h3},                 33};

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // Annul at step 10, then an immediate 9/3.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    @(posedge clk); #1;
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    measure(lat, zok);
    check("annul_latency", 64'(lat), 64'd33);
    check("annul_result", bus.result_o, {32'h0, 32'h3});
    check("annul_zero_while_busy", 64'(zok), 64'd1);
    drop_start();

    // Annul held in DivFree blocks the request.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    measure(lat, zok);
    check("free_annul_latency", 64'(lat), 64'd33);
    check("free_annul_result", bus.result_o, {32'h0, 32'h3});
    drop_start();

    // Asynchronous reset mid-DivOn, start held through release.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_on_ready", 64'(bus.ready_o), 64'd0);
    check("rst_on_result", bus.result_o, 64'd0);
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.signed_div_i = 1'b0;
    rst_n = 1'b1;
    measure(lat, zok);
    check("rst_restart_latency", 64'(lat), 64'd33);
    check("rst_restart_result", bus.result_o, {32'h2, 32'hE});

    // Asynchronous reset while a result is presented.
    #3 rst_n = 1'b0;
    #1;
    check("rst_end_ready", 64'(bus.ready_o), 64'd0);
    check("rst_end_result", bus.result_o, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
